// File: rtl/serial_rx_pkg.sv
// Shared types and widths for the 8N1 serial receiver.
package serial_rx_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/serial_rx_if.sv
// Byte delivery interface: valid/ready handshake plus error pulses.
interface serial_rx_if;

  logic [serial_rx_pkg::DATA_W-1:0] data;
  logic                             valid;
  logic                             ready;
  logic                             frame_err;
  logic                             overrun;

  modport master (output data, output valid, output frame_err, output overrun, input ready);
  modport slave  (input data, input valid, input frame_err, input overrun, output ready);

endinterface

// File: rtl/serial_rx_sync_2ff.sv
// Two-stage synchroniser for an asynchronous input; resets to the idle-high level.
module serial_rx_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/serial_rx.sv
// 8N1 UART receiver: start-edge re-phased fractional sampling, valid/ready
// byte delivery, framing-error and overrun pulses.
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 48_000_000,
  parameter int unsigned BIT_FREQ = 115_200,
  parameter int unsigned ACC_W    = 32
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        rx,
  serial_rx_if.master bus
);

  logic rx_s;

  serial_rx_sync_2ff u_sync (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  rx_state_e          state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   acc_sum_c;
  logic               tick_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;

  // Next-state logic; the accumulator free-runs and is re-phased on each start edge.
  always_comb begin
    acc_sum_c = acc_q + ACC_W'(BIT_FREQ);
    tick_c    = (acc_sum_c >= ACC_W'(CLK_FREQ));
    state_d   = state_q;
    acc_d     = tick_c ? (acc_sum_c - ACC_W'(CLK_FREQ)) : acc_sum_c;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q && !bus.ready;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          acc_d   = ACC_W'(CLK_FREQ / 2);
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick_c) begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          shift_d = {rx_s, shift_q[DATA_W-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick_c) begin
          if (rx_s) begin
            // A byte accepted this very cycle frees the slot for the new one.
            if (!valid_q || bus.ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx at CLK_FREQ=16, BIT_FREQ=3 with a fractional-rate line driver.
module tb_serial_rx;

  localparam int unsigned CF = 16;
  localparam int unsigned BF = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;

  serial_rx_if bus ();

  serial_rx #(
    .CLK_FREQ (CF),
    .BIT_FREQ (BF),
    .ACC_W    (8)
  ) dut (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int tx_acc = 0;
  logic [7:0] rx_q[$];

  // Observe handshakes and pulses mid-cycle.
  always @(negedge clk) begin
    if (bus.valid && bus.ready) rx_q.push_back(bus.data);
    if (bus.frame_err) fe_cnt++;
    if (bus.overrun) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int idx);
    if (idx < rx_q.size()) return 32'(rx_q[idx]);
    return 32'hDEAD_BEEF;
  endfunction

  // Drive the first nbits of a frame; each bit lasts until the line-rate accumulator wraps.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = fr[i];
      do begin
        @(negedge clk);
        tx_acc += BF;
      end while (tx_acc < CF);
      tx_acc -= CF;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.ready = 1'b1;
    wait_cyc(3);
    check("rst_data",  32'(bus.data), 32'h00);
    check("rst_valid", 32'(bus.valid), 32'h0);
    check("rst_ferr",  32'(bus.frame_err), 32'h0);
    check("rst_ovr",   32'(bus.overrun), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(5);

    // Single byte "K"
    send_frame(8'h4B, 1'b1, 10);
    wait_cyc(10);
    check("k_count", 32'(rx_q.size()), 32'd1);
    check("k_data",  q_at(0), 32'h4B);
    check("k_ferr",  32'(fe_cnt), 32'd0);
    check("k_ovr",   32'(ov_cnt), 32'd0);
    check("k_valid_low", 32'(bus.valid), 32'h0);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 10);
    send_frame(8'hFF, 1'b1, 10);
    send_frame(8'hA5, 1'b1, 10);
    wait_cyc(10);
    check("b2b_count", 32'(rx_q.size()), 32'd4);
    check("b2b_0", q_at(1), 32'h00);
    check("b2b_1", q_at(2), 32'hFF);
    check("b2b_2", q_at(3), 32'hA5);

    // One-cycle glitch
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    wait_cyc(20);
    check("glitch_count", 32'(rx_q.size()), 32'd4);
    check("glitch_ferr",  32'(fe_cnt), 32'd0);

    // Stop bit low followed by a held-low line
    send_frame(8'h55, 1'b0, 10);
    wait_cyc(40);
    check("brk_count", 32'(rx_q.size()), 32'd4);
    check("brk_ferr",  32'(fe_cnt), 32'd1);
    check("brk_data_kept", 32'(bus.data), 32'hA5);
    rx = 1'b1;
    wait_cyc(10);
    send_frame(8'h3C, 1'b1, 10);
    wait_cyc(10);
    check("post_brk_count", 32'(rx_q.size()), 32'd5);
    check("post_brk_data",  q_at(4), 32'h3C);
    check("post_brk_ferr",  32'(fe_cnt), 32'd1);

    // Overrun with consumer stalled
    bus.ready = 1'b0;
    wait_cyc(2);
    send_frame(8'h11, 1'b1, 10);
    send_frame(8'h22, 1'b1, 10);
    wait_cyc(10);
    check("ovr_valid", 32'(bus.valid), 32'h1);
    check("ovr_data",  32'(bus.data), 32'h11);
    check("ovr_pulses", 32'(ov_cnt), 32'd1);
    check("ovr_count",  32'(rx_q.size()), 32'd5);
    @(posedge clk);
    #1 bus.ready = 1'b1;
    wait_cyc(3);
    check("ovr_accept_count", 32'(rx_q.size()), 32'd6);
    check("ovr_accept_data",  q_at(5), 32'h11);
    check("ovr_valid_low",    32'(bus.valid), 32'h0);

    // Reset during DATA bit 4
    send_frame(8'hE7, 1'b1, 5);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data",  32'(bus.data), 32'h00);
    check("mid_rst_valid", 32'(bus.valid), 32'h0);
    check("mid_rst_ferr",  32'(bus.frame_err), 32'h0);
    check("mid_rst_ovr",   32'(bus.overrun), 32'h0);
    rx = 1'b1;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(5);
    send_frame(8'h96, 1'b1, 10);
    wait_cyc(10);
    check("post_rst_count", 32'(rx_q.size()), 32'd7);
    check("post_rst_data",  q_at(6), 32'h96);
    check("post_rst_ferr",  32'(fe_cnt), 32'd1);
    check("post_rst_ovr",   32'(ov_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
